// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: sequencer state encoding, default depths,
// and the per-stage control bundle driven by the sequencer.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DSTALL = 2'd1;
    localparam logic [1:0] ST_CWAIT  = 2'd2;

    localparam int STALL_MAX_DEF    = 3;
    localparam int CTRL_BUBBLES_DEF = 3;
    localparam int CNT_W_DEF        = 2;

    typedef struct packed {
        logic pc_write;
        logic pc_src_sel;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic freeze;
    } stage_ctrl_t;

    //                                          pcw   pcsrc ifidw ifidf idexf frz
    localparam stage_ctrl_t CTRL_DEFAULT   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_RESET     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam stage_ctrl_t CTRL_DSTALL    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_CTRL_SEEN = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_CWAIT     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam stage_ctrl_t CTRL_RESOLVE   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    // A requested depth of 0 still costs one bubble; anything deeper than the
    // sequencer supports is capped.
    function automatic int unsigned clamp_depth(input logic [1:0] depth,
                                                input int unsigned max_depth);
        int unsigned d;
        d = 32'(depth);
        if (d == 0)
            d = 1;
        if (d > max_depth)
            d = max_depth;
        return d;
    endfunction

endpackage

// File: rtl/pipeline_sequencer_if.sv
// Hazard/branch event inputs and per-stage control outputs of the pipeline sequencer.
interface pipeline_sequencer_if;

    logic        DataHazard;
    logic [1:0]  HazardDepth;
    logic        CtrlDecode;
    logic        BranchResolved;
    logic        BranchTaken;
    logic        MemBusy;

    logic        PC_Write;
    logic        PCSrcSel;
    logic        IFID_Write;
    logic        IFID_Flush;
    logic        IDEX_Flush;
    logic        Freeze;
    logic        Busy;
    logic        CtrlTimeout;
    logic [15:0] StallCycles;

    modport master (
        output DataHazard, HazardDepth, CtrlDecode, BranchResolved, BranchTaken, MemBusy,
        input  PC_Write, PCSrcSel, IFID_Write, IFID_Flush, IDEX_Flush, Freeze,
        input  Busy, CtrlTimeout, StallCycles
    );

    modport slave (
        input  DataHazard, HazardDepth, CtrlDecode, BranchResolved, BranchTaken, MemBusy,
        output PC_Write, PCSrcSel, IFID_Write, IFID_Flush, IDEX_Flush, Freeze,
        output Busy, CtrlTimeout, StallCycles
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear, used for performance counters.
module sat_counter #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst)
            count_reg <= RESET_VALUE;
        else if (clr)
            count_reg <= '0;
        else if (inc && (count_reg != {WIDTH{1'b1}}))
            count_reg <= count_reg + WIDTH'(1);
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_sequencer.sv
// Stall/flush sequencer: turns hazard and branch-resolution events into PC,
// IF/ID and ID/EX control, with memory-wait freeze and a stall-cycle counter.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int          STALL_MAX      = STALL_MAX_DEF,
    parameter int          CTRL_BUBBLES   = CTRL_BUBBLES_DEF,
    parameter int          CNT_W          = CNT_W_DEF,
    // Power-on/reset value of StallCycles; nonzero only to exercise saturation.
    parameter logic [15:0] STALL_CNT_INIT = 16'h0000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    pipeline_sequencer_if.slave  bus
);

    logic [1:0]       state_reg;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout_reg;
    logic             timeout_next;
    logic [CNT_W-1:0] depth;
    stage_ctrl_t      ctrl;
    logic [15:0]      stall_count;

    assign depth = CNT_W'(clamp_depth(bus.HazardDepth, STALL_MAX));

    always_comb begin
        ctrl         = CTRL_DEFAULT;
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;

        // A busy data memory freezes everything, including branch resolution in MEM.
        if (bus.MemBusy) begin
            ctrl = CTRL_FREEZE;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (bus.DataHazard) begin
                        ctrl = CTRL_DSTALL;
                        if (depth > CNT_W'(1)) begin
                            cnt_next   = depth - CNT_W'(1);
                            state_next = ST_DSTALL;
                        end
                    end else if (bus.CtrlDecode) begin
                        ctrl       = CTRL_CTRL_SEEN;
                        cnt_next   = CNT_W'(CTRL_BUBBLES);
                        state_next = ST_CWAIT;
                    end
                end

                ST_DSTALL: begin
                    ctrl     = CTRL_DSTALL;
                    cnt_next = cnt_reg - CNT_W'(1);
                    if (cnt_reg == CNT_W'(1))
                        state_next = ST_RUN;
                end

                ST_CWAIT: begin
                    if (bus.BranchResolved) begin
                        ctrl            = CTRL_RESOLVE;
                        ctrl.pc_src_sel = bus.BranchTaken;
                        state_next      = ST_RUN;
                    end else if (cnt_reg == '0) begin
                        timeout_next = 1'b1;
                        state_next   = ST_RUN;
                    end else begin
                        ctrl     = CTRL_CWAIT;
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end

                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end

        if (Reset)
            ctrl = CTRL_RESET;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    sat_counter #(
        .WIDTH       (16),
        .RESET_VALUE (STALL_CNT_INIT)
    ) u_stall_cnt (
        .clk   (Clk),
        .srst  (Reset),
        .clr   (1'b0),
        .inc   (~ctrl.pc_write),
        .count (stall_count)
    );

    assign bus.PC_Write    = ctrl.pc_write;
    assign bus.PCSrcSel    = ctrl.pc_src_sel;
    assign bus.IFID_Write  = ctrl.ifid_write;
    assign bus.IFID_Flush  = ctrl.ifid_flush;
    assign bus.IDEX_Flush  = ctrl.idex_flush;
    assign bus.Freeze      = ctrl.freeze;
    assign bus.Busy        = (state_reg != ST_RUN);
    assign bus.CtrlTimeout = timeout_reg;
    assign bus.StallCycles = stall_count;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: per-cycle expectations queued at drive
// time and checked at the following falling edge.
module tb_pipeline_sequencer;

    logic Clk;
    logic rst;
    logic rst2;

    pipeline_sequencer_if bus ();
    pipeline_sequencer_if bus2 ();

    pipeline_sequencer dut (
        .Clk   (Clk),
        .Reset (rst),
        .bus   (bus.slave)
    );

    pipeline_sequencer #(.STALL_CNT_INIT(16'hFFFC)) dut_sat (
        .Clk   (Clk),
        .Reset (rst2),
        .bus   (bus2.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // {PC_Write, PCSrcSel, IFID_Write, IFID_Flush, IDEX_Flush, Freeze}
    localparam logic [5:0] C_DEF = 6'b101000;
    localparam logic [5:0] C_RST = 6'b000110;
    localparam logic [5:0] C_DST = 6'b000010;
    localparam logic [5:0] C_CTL = 6'b001100;
    localparam logic [5:0] C_CWT = 6'b001110;
    localparam logic [5:0] C_BRT = 6'b111100;
    localparam logic [5:0] C_BRN = 6'b101100;
    localparam logic [5:0] C_FRZ = 6'b000001;

    typedef struct {
        string       tag;
        logic [5:0]  ctl;
        logic        busy;
        logic        tmo;
        logic [15:0] stall;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sat_sb[$];
    logic [15:0] exp_stall;
    int          tests_run;
    int          tests_failed;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] req);
        tests_run++;
        assert (obs === req) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic cyc(input string tag, input logic r, input logic dh, input logic [1:0] dep,
                       input logic cd, input logic br, input logic bt, input logic mb,
                       input logic [5:0] ectl, input logic ebusy, input logic etmo);
        exp_t e;
        exp_t got;
        logic [5:0] obs_ctl;
        rst                = r;
        bus.DataHazard     = dh;
        bus.HazardDepth    = dep;
        bus.CtrlDecode     = cd;
        bus.BranchResolved = br;
        bus.BranchTaken    = bt;
        bus.MemBusy        = mb;
        e.tag   = tag;
        e.ctl   = ectl;
        e.busy  = ebusy;
        e.tmo   = etmo;
        e.stall = exp_stall;
        sb.push_back(e);
        if (r)
            exp_stall = 16'h0000;
        else if (!ectl[5] && exp_stall != 16'hFFFF)
            exp_stall = exp_stall + 16'h0001;
        @(negedge Clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd0, 16'd1);
        end else begin
            got = sb.pop_front();
            obs_ctl = {bus.PC_Write, bus.PCSrcSel, bus.IFID_Write,
                       bus.IFID_Flush, bus.IDEX_Flush, bus.Freeze};
            chk({got.tag, "_ctl"},   {10'd0, obs_ctl},         {10'd0, got.ctl});
            chk({got.tag, "_busy"},  {15'd0, bus.Busy},        {15'd0, got.busy});
            chk({got.tag, "_tmo"},   {15'd0, bus.CtrlTimeout}, {15'd0, got.tmo});
            chk({got.tag, "_stall"}, bus.StallCycles,          got.stall);
            $display("[TB] %-12s ctl=%b busy=%b tmo=%b stall=%0d",
                     got.tag, obs_ctl, bus.Busy, bus.CtrlTimeout, bus.StallCycles);
        end
        @(posedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] e_sat;
        tests_run    = 0;
        tests_failed = 0;
        exp_stall    = 16'h0000;
        rst  = 1'b1;
        rst2 = 1'b1;
        bus.DataHazard = 1'b0;  bus.HazardDepth = 2'd0; bus.CtrlDecode = 1'b0;
        bus.BranchResolved = 1'b0; bus.BranchTaken = 1'b0; bus.MemBusy = 1'b0;
        bus2.DataHazard = 1'b0; bus2.HazardDepth = 2'd0; bus2.CtrlDecode = 1'b0;
        bus2.BranchResolved = 1'b0; bus2.BranchTaken = 1'b0; bus2.MemBusy = 1'b0;
        @(posedge Clk);
        #1;

        //   tag            rst dh dep  cd br bt mb  ctl    busy tmo
        cyc("reset0",       1, 0, 2'd0, 0, 0, 0, 0, C_RST, 0, 0);
        cyc("reset1",       1, 0, 2'd0, 0, 0, 0, 0, C_RST, 0, 0);
        cyc("idle",         0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // depth 2: two bubbles
        cyc("d2_b0",        0, 1, 2'd2, 0, 0, 0, 0, C_DST, 0, 0);
        cyc("d2_b1",        0, 0, 2'd0, 0, 0, 0, 0, C_DST, 1, 0);
        cyc("d2_end",       0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // depth 0 behaves as 1
        cyc("d0_b0",        0, 1, 2'd0, 0, 0, 0, 0, C_DST, 0, 0);
        cyc("d0_end",       0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // depth 3: three bubbles, hazard inputs ignored while stalled
        cyc("d3_b0",        0, 1, 2'd3, 0, 0, 0, 0, C_DST, 0, 0);
        cyc("d3_b1",        0, 1, 2'd3, 1, 0, 0, 0, C_DST, 1, 0);
        cyc("d3_b2",        0, 0, 2'd0, 0, 0, 0, 0, C_DST, 1, 0);
        cyc("d3_end",       0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // branch resolved taken two cycles after decode
        cyc("brt_dec",      0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 0);
        cyc("brt_wait",     0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 0);
        cyc("brt_res",      0, 0, 2'd0, 0, 1, 1, 0, C_BRT, 1, 0);
        cyc("brt_end",      0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // not taken
        cyc("brn_dec",      0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 0);
        cyc("brn_wait",     0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 0);
        cyc("brn_res",      0, 0, 2'd0, 0, 1, 0, 0, C_BRN, 1, 0);
        cyc("brn_end",      0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // MemBusy in CWAIT hides a resolution; MEM re-presents it afterwards
        cyc("mbw_dec",      0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 0);
        cyc("mbw_frz",      0, 0, 2'd0, 0, 1, 1, 1, C_FRZ, 1, 0);
        cyc("mbw_res",      0, 0, 2'd0, 0, 1, 1, 0, C_BRT, 1, 0);
        cyc("mbw_end",      0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);
        // timeout: CWAIT spans CTRL_BUBBLES+1 cycles
        cyc("to_dec",       0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 0);
        cyc("to_w3",        0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 0);
        cyc("to_w2",        0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 0);
        cyc("to_w1",        0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 0);
        cyc("to_w0",        0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 1, 0);
        cyc("to_sticky",    0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 1);
        // MemBusy for 3 cycles in DSTALL with one bubble left
        cyc("mbd_b0",       0, 1, 2'd2, 0, 0, 0, 0, C_DST, 0, 1);
        cyc("mbd_f0",       0, 1, 2'd0, 0, 0, 0, 1, C_FRZ, 1, 1);
        cyc("mbd_f1",       0, 0, 2'd0, 1, 0, 0, 1, C_FRZ, 1, 1);
        cyc("mbd_f2",       0, 0, 2'd0, 0, 0, 0, 1, C_FRZ, 1, 1);
        cyc("mbd_b1",       0, 0, 2'd0, 0, 0, 0, 0, C_DST, 1, 1);
        cyc("mbd_end",      0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 1);
        // MemBusy in RUN blocks a control decode
        cyc("mbr_frz",      0, 0, 2'd0, 1, 0, 0, 1, C_FRZ, 0, 1);
        cyc("mbr_end",      0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 1);
        // data hazard beats control decode; decode re-presented afterwards
        cyc("dc_stall",     0, 1, 2'd0, 1, 0, 0, 0, C_DST, 0, 1);
        cyc("dc_dec",       0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 1);
        cyc("dc_res",       0, 0, 2'd0, 0, 1, 1, 0, C_BRT, 1, 1);
        cyc("dc_end",       0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 1);
        // reset in CWAIT aborts to RUN and clears timeout and counter
        cyc("rc_dec",       0, 0, 2'd0, 1, 0, 0, 0, C_CTL, 0, 1);
        cyc("rc_wait",      0, 0, 2'd0, 0, 0, 0, 0, C_CWT, 1, 1);
        cyc("rc_reset",     1, 0, 2'd0, 0, 0, 0, 0, C_RST, 1, 1);
        cyc("rc_after",     0, 0, 2'd0, 0, 0, 0, 0, C_DEF, 0, 0);

        // saturation on the preloaded instance: frozen every cycle
        rst2 = 1'b0;
        bus2.MemBusy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            e_sat = (i < 3) ? (16'hFFFC + 16'(i)) : 16'hFFFF;
            sat_sb.push_back(e_sat);
            @(negedge Clk);
            if (sat_sb.size() == 0) begin
                chk("sat_sb_empty", 16'd0, 16'd1);
            end else begin
                e_sat = sat_sb.pop_front();
                chk("sat_count", bus2.StallCycles, e_sat);
                $display("[TB] sat%0d        stall=%h", i, bus2.StallCycles);
            end
            @(posedge Clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
